// File: rtl/draw_cmd_queue_pkg.sv
// Shared draw-command types: header word layout, collector states and the nargs clamp helper.
package draw_cmd_queue_pkg;

    localparam int unsigned WORD_W  = 16;
    localparam int unsigned OP_W    = 4;
    localparam int unsigned NARGS_W = 3;
    localparam int unsigned IMM_W   = 9;
    localparam int unsigned HDR_W   = OP_W + NARGS_W + IMM_W;

    typedef struct packed {
        logic [OP_W-1:0]    op;
        logic [NARGS_W-1:0] nargs;
        logic [IMM_W-1:0]   imm;
    } header_t;

    typedef enum logic {
        IDLE,
        ARGS
    } collState_t;

    function automatic logic [NARGS_W-1:0] clampNargs(
        input logic [NARGS_W-1:0] raw,
        input logic [NARGS_W-1:0] maxArgs
    );
        return (raw > maxArgs) ? maxArgs : raw;
    endfunction

endpackage

// File: rtl/draw_cmd_queue_cmd_fifo.sv
// Synchronous show-ahead FIFO; a push into a full FIFO is dropped even if a pop shares the edge.
module cmd_fifo #(
    parameter int unsigned WIDTH = 80,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wrData,
    output logic [WIDTH-1:0]         rdData,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic             wrOk;
    logic             rdOk;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign wrOk  = push && !full;
    assign rdOk  = pop && !empty;

    // Pointers wrap naturally; count tracks occupancy 0..DEPTH.
    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (wrOk) wrPtr <= wrPtr + PTR_W'(1);
            if (rdOk) rdPtr <= rdPtr + PTR_W'(1);
            count <= count + CNT_W'(wrOk) - CNT_W'(rdOk);
        end
    end

    always_ff @(posedge clk) begin
        if (wrOk) mem[wrPtr] <= wrData;
    end

    assign rdData = mem[rdPtr];

endmodule

// File: rtl/draw_cmd_queue.sv
// Assembles 16-bit pram writes into draw commands and queues them for the draw unit.
module draw_cmd_queue
    import draw_cmd_queue_pkg::*;
#(
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned MAX_ARGS = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        we,
    input  logic [15:0]                 dataIn,
    output logic                        full,
    output logic                        cmd_valid,
    input  logic                        cmd_ready,
    output logic [3:0]                  cmd_op,
    output logic [2:0]                  cmd_nargs,
    output logic [8:0]                  cmd_imm,
    output logic [16*MAX_ARGS-1:0]      cmd_args,
    output logic [$clog2(DEPTH):0]      level,
    output logic                        overflow,
    output logic                        fmt_err
);

    localparam int unsigned ARGS_W = WORD_W * MAX_ARGS;
    localparam int unsigned REC_W  = HDR_W + ARGS_W;

    collState_t          state;
    collState_t          stateNext;
    header_t             hdrQ;
    header_t             hdrNext;
    header_t             hdrIn;
    logic [ARGS_W-1:0]   argsQ;
    logic [ARGS_W-1:0]   argsNext;
    logic [NARGS_W-1:0]  argIdx;
    logic [NARGS_W-1:0]  argIdxNext;
    logic                pushC;
    logic                fmtErrSet;
    logic [REC_W-1:0]    pushRec;
    logic [REC_W-1:0]    headRec;
    header_t             headHdr;
    logic                fifoFull;
    logic                fifoEmpty;

    assign hdrIn = header_t'(dataIn);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= stateNext;
    end

    // Collector: advances only on write strobes; pushes on the edge that takes the last word.
    always_comb begin
        stateNext  = state;
        hdrNext    = hdrQ;
        argsNext   = argsQ;
        argIdxNext = argIdx;
        pushC      = 1'b0;
        fmtErrSet  = 1'b0;
        pushRec    = {hdrQ, argsQ};
        if (we) begin
            case (state)
                IDLE: begin
                    hdrNext       = hdrIn;
                    hdrNext.nargs = clampNargs(hdrIn.nargs, NARGS_W'(MAX_ARGS));
                    fmtErrSet     = (hdrIn.nargs > NARGS_W'(MAX_ARGS));
                    argsNext      = '0;
                    argIdxNext    = '0;
                    if (hdrNext.nargs == '0) begin
                        pushC   = 1'b1;
                        pushRec = {hdrNext, ARGS_W'(0)};
                    end else begin
                        stateNext = ARGS;
                    end
                end
                ARGS: begin
                    for (int k = 0; k < int'(MAX_ARGS); k++) begin
                        if (argIdx == NARGS_W'(k)) argsNext[k*WORD_W +: WORD_W] = dataIn;
                    end
                    argIdxNext = argIdx + NARGS_W'(1);
                    if (argIdxNext == hdrQ.nargs) begin
                        pushC     = 1'b1;
                        pushRec   = {hdrQ, argsNext};
                        stateNext = IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hdrQ     <= '0;
            argsQ    <= '0;
            argIdx   <= '0;
            overflow <= 1'b0;
            fmt_err  <= 1'b0;
        end else begin
            hdrQ   <= hdrNext;
            argsQ  <= argsNext;
            argIdx <= argIdxNext;
            if (pushC && fifoFull) overflow <= 1'b1;
            if (fmtErrSet)         fmt_err  <= 1'b1;
        end
    end

    cmd_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .push   (pushC),
        .pop    (cmd_ready),
        .wrData (pushRec),
        .rdData (headRec),
        .count  (level),
        .full   (fifoFull),
        .empty  (fifoEmpty)
    );

    // Head fields are forced to zero while nothing is queued so outputs read 0 after reset.
    assign headHdr   = header_t'(headRec[REC_W-1 -: HDR_W]);
    assign full      = fifoFull;
    assign cmd_valid = !fifoEmpty;
    assign cmd_op    = cmd_valid ? headHdr.op    : '0;
    assign cmd_nargs = cmd_valid ? headHdr.nargs : '0;
    assign cmd_imm   = cmd_valid ? headHdr.imm   : '0;
    assign cmd_args  = cmd_valid ? headRec[ARGS_W-1:0] : '0;

endmodule

// File: tb/tb_draw_cmd_queue.sv
// Scoreboard bench for draw_cmd_queue: stimulus queues expected commands, a monitor checks each accepted head.
module tb_draw_cmd_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        we;
    logic [15:0] dataIn;
    logic        full;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_op;
    logic [2:0]  cmd_nargs;
    logic [8:0]  cmd_imm;
    logic [63:0] cmd_args;
    logic [3:0]  level;
    logic        overflow;
    logic        fmt_err;

    int total = 0;
    int bad   = 0;
    logic [79:0] expQ [$];

    draw_cmd_queue #(.DEPTH(8), .MAX_ARGS(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .we        (we),
        .dataIn    (dataIn),
        .full      (full),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_nargs (cmd_nargs),
        .cmd_imm   (cmd_imm),
        .cmd_args  (cmd_args),
        .level     (level),
        .overflow  (overflow),
        .fmt_err   (fmt_err)
    );

    always #5 clk = ~clk;

    function automatic logic [79:0] mk(input int op, input int nargs, input int imm, input logic [63:0] args);
        return {4'(op), 3'(nargs), 9'(imm), args};
    endfunction

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [15:0] w);
        we     = 1'b1;
        dataIn = w;
        @(posedge clk);
        #1;
        we     = 1'b0;
    endtask

    // Monitor: every accepted head must match the oldest expected command.
    always @(negedge clk) begin
        if (!reset && cmd_valid && cmd_ready) begin
            if (expQ.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_cmd: got %0h expected none", {cmd_op, cmd_nargs, cmd_imm, cmd_args});
            end else begin
                chk("cmd", {cmd_op, cmd_nargs, cmd_imm, cmd_args}, expQ.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        reset     = 1'b1;
        we        = 1'b0;
        dataIn    = '0;
        cmd_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_level", 80'(level), 80'(0));
        chk("rst_flags", 80'({cmd_valid, full, overflow, fmt_err}), 80'(0));

        // 1: zero-arg command, show-ahead head after one cycle
        expQ.push_back(mk(1, 0, 5, 64'h0));
        wr(16'h1005);
        @(negedge clk);
        chk("t1_valid", 80'(cmd_valid), 80'(1));
        chk("t1_level", 80'(level), 80'(1));
        chk("t1_head", 80'({cmd_op, cmd_nargs, cmd_imm}), 80'({4'd1, 3'd0, 9'd5}));
        step();
        cmd_ready = 1'b1;
        step();
        cmd_ready = 1'b0;

        // 2: two-arg command, valid only after the last arg
        wr(16'h2400);
        @(negedge clk);
        chk("t2_valid_hdr", 80'(cmd_valid), 80'(0));
        wr(16'hAAAA);
        @(negedge clk);
        chk("t2_valid_a0", 80'(cmd_valid), 80'(0));
        expQ.push_back(mk(2, 2, 0, 64'h0000_0000_5555_AAAA));
        wr(16'h5555);
        @(negedge clk);
        chk("t2_valid_a1", 80'(cmd_valid), 80'(1));
        chk("t2_args_lo", 80'(cmd_args[31:0]), 80'(32'h5555_AAAA));
        chk("t2_args_hi", 80'(cmd_args[63:32]), 80'(0));
        step();
        cmd_ready = 1'b1;
        step();
        cmd_ready = 1'b0;

        // 3: fill to DEPTH, drop the 9th, drain in order
        for (int k = 1; k <= 8; k++) begin
            expQ.push_back(mk(k, 0, k, 64'h0));
            wr(16'((k << 12) | k));
            if (k == 7) begin
                @(negedge clk);
                chk("t3_full_at7", 80'(full), 80'(0));
            end
        end
        @(negedge clk);
        chk("t3_full", 80'(full), 80'(1));
        chk("t3_level8", 80'(level), 80'(8));
        wr(16'h9009);
        @(negedge clk);
        chk("t3_overflow", 80'(overflow), 80'(1));
        chk("t3_level_after_drop", 80'(level), 80'(8));
        chk("t3_head_op", 80'(cmd_op), 80'(1));
        step();
        cmd_ready = 1'b1;
        repeat (8) step();
        cmd_ready = 1'b0;
        @(negedge clk);
        chk("t3_drained_valid", 80'(cmd_valid), 80'(0));
        chk("t3_drained_level", 80'(level), 80'(0));

        // 4: stream with cmd_ready held, past pointer wrap
        step();
        cmd_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            expQ.push_back(mk(i & 15, 0, i + 100, 64'h0));
            wr(16'(((i & 15) << 12) | (i + 100)));
            @(negedge clk);
            chk("t4_level", 80'(level), 80'(1));
        end
        step();
        @(negedge clk);
        chk("t4_end_level", 80'(level), 80'(0));
        step();

        // 5: nargs=7 clamps to 4, 5th word is a new header
        expQ.push_back(mk(3, 4, 0, 64'h4444_3333_2222_1111));
        wr(16'h3E00);
        @(negedge clk);
        chk("t5_fmt_err", 80'(fmt_err), 80'(1));
        chk("t5_valid_hdr", 80'(cmd_valid), 80'(0));
        wr(16'h1111);
        wr(16'h2222);
        wr(16'h3333);
        wr(16'h4444);
        @(negedge clk);
        chk("t5_valid_args", 80'(cmd_valid), 80'(1));
        expQ.push_back(mk(1, 0, 7, 64'h0));
        wr(16'h1007);
        @(negedge clk);
        chk("t5_valid_next", 80'(cmd_valid), 80'(1));
        step();
        @(negedge clk);
        chk("t5_level", 80'(level), 80'(0));
        step();
        cmd_ready = 1'b0;

        // 6: reset discards a partial command
        wr(16'h2400);
        wr(16'h1234);
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("t6_level", 80'(level), 80'(0));
        chk("t6_flags", 80'({cmd_valid, full, overflow, fmt_err}), 80'(0));
        step();
        cmd_ready = 1'b1;
        expQ.push_back(mk(1, 0, 1, 64'h0));
        wr(16'h1001);
        @(negedge clk);
        chk("t6_valid", 80'(cmd_valid), 80'(1));
        step();
        @(negedge clk);
        chk("t6_level_end", 80'(level), 80'(0));
        cmd_ready = 1'b0;
        chk("scoreboard_empty", 80'(expQ.size()), 80'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
